// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame sequencer.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } ws_state_e;

    localparam int unsigned DEF_T0H_CYC  = 20;
    localparam int unsigned DEF_T1H_CYC  = 40;
    localparam int unsigned DEF_TBIT_CYC = 63;
    localparam int unsigned DEF_TRST_CYC = 2800;

    // Smallest counter width able to hold every value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit period: high for T0H/T1H cycles depending on the bit, low for the rest.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
    parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
    parameter int unsigned TBIT_CYC = DEF_TBIT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic bit_val,
    output logic dout_hi,
    output logic bit_end
);

    localparam int unsigned CNT_W = cnt_width(TBIT_CYC - 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0] T0H_LIM  = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H_LIM  = CNT_W'(T1H_CYC);

    logic [CNT_W-1:0] bit_cnt;

    // The counter idles at zero so the first cycle of SEND is cycle 0 of bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (!run || bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign bit_end = run && (bit_cnt == CNT_LAST);
    assign dout_hi = run && (bit_cnt < (bit_val ? T1H_LIM : T0H_LIM));

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer: prefetches one bank of pixel words from the pixel RAM and
// streams them gap-free onto the WS2812 line, followed by the latch low time.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int unsigned LED_NUM    = 16,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = $clog2(LED_NUM) + 1,
    parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
    parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
    parameter int unsigned TBIT_CYC   = DEF_TBIT_CYC,
    parameter int unsigned TRST_CYC   = DEF_TRST_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bank,
    input  logic [ADDR_WIDTH-1:0] led_count,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  dout,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PIX_W  = ADDR_WIDTH - 1;
    localparam int unsigned BIDX_W = cnt_width(DATA_WIDTH - 1);
    localparam int unsigned PH_W   = cnt_width(TRST_CYC);

    localparam logic [ADDR_WIDTH-1:0] N_MAX      = ADDR_WIDTH'(LED_NUM);
    localparam logic [BIDX_W-1:0]     BIT_LAST   = BIDX_W'(DATA_WIDTH - 1);
    localparam logic [PH_W-1:0]       PRIME_LAST = PH_W'(1);
    localparam logic [PH_W-1:0]       TRST_LAST  = PH_W'(TRST_CYC);

    if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
        $error("ws2812_frame_ctrl: bit timing must satisfy T0H < T1H < TBIT");
    end
    if (LED_NUM < 2 || (LED_NUM & (LED_NUM - 1)) != 0) begin : g_bad_led_num
        $error("ws2812_frame_ctrl: LED_NUM must be a power of two >= 2");
    end

    ws_state_e               state;
    ws_state_e               state_d;
    logic                    bank_q;
    logic [ADDR_WIDTH-1:0]   n_q;
    logic [ADDR_WIDTH-1:0]   n_clamp;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [PIX_W-1:0]        pix_idx;
    logic [BIDX_W-1:0]       bit_idx;
    logic [DATA_WIDTH-1:0]   sr;
    logic [PH_W-1:0]         phase_cnt;
    logic                    dout_hi;
    logic                    bit_end;
    logic                    word_end;
    logic                    last_pix;
    logic                    frame_end;

    assign n_clamp   = (led_count > N_MAX) ? N_MAX : led_count;
    assign last_pix  = ({1'b0, pix_idx} == (n_q - ADDR_WIDTH'(1)));
    assign word_end  = bit_end && (bit_idx == BIT_LAST);
    assign frame_end = word_end && last_pix;

    ws2812_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state == ST_SEND),
        .bit_val (sr[DATA_WIDTH-1]),
        .dout_hi (dout_hi),
        .bit_end (bit_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: state_d takes a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_clamp == '0) ? ST_LATCH : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (phase_cnt == PRIME_LAST) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_end) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_cnt == TRST_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_LATCH) && (phase_cnt == TRST_LAST);
        dout = dout_hi;
    end

    assign ram_raddr = addr_q;

    // Shared by PRIME (RAM read latency) and LATCH (reset low time), zeroed on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state_d != state || state == ST_IDLE || state == ST_SEND) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= 1'b0;
            n_q     <= '0;
            pix_idx <= '0;
            bit_idx <= '0;
            sr      <= '0;
            addr_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        bank_q  <= bank;
                        n_q     <= n_clamp;
                        pix_idx <= '0;
                        bit_idx <= '0;
                        addr_q  <= {bank, PIX_W'(0)};
                    end
                end
                ST_PRIME: begin
                    if (phase_cnt == PRIME_LAST) begin
                        sr      <= ram_q;
                        bit_idx <= '0;
                        addr_q  <= {bank_q, pix_idx + PIX_W'(1)};
                    end
                end
                ST_SEND: begin
                    if (bit_end) begin
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            // Address already points one pixel ahead, so ram_q holds the next word.
                            if (!last_pix) begin
                                sr      <= ram_q;
                                pix_idx <= pix_idx + PIX_W'(1);
                                addr_q  <= {bank_q, pix_idx + PIX_W'(2)};
                            end
                        end else begin
                            sr      <= {sr[DATA_WIDTH-2:0], 1'b0};
                            bit_idx <= bit_idx + BIDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    a_done_ends_busy: assert property (@(posedge clk) disable iff (!rst_n) done |=> !busy);
    a_bank_stable:    assert property (@(posedge clk) disable iff (!rst_n)
                                       (busy && $past(busy)) |-> $stable(bank_q));

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: table of frames plus hand-written mid-frame corner cases,
// pulse widths checked against a scoreboard filled from the bench's own RAM image.
module tb_ws2812_frame_ctrl;

    localparam int LED_NUM = 16;
    localparam int AW      = 5;
    localparam int DW      = 24;
    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int TBIT    = 63;
    localparam int TRST    = 2800;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bank;
    logic [AW-1:0] led_count;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_q;
    logic          dout;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:2*LED_NUM-1];

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_raddr];

    ws2812_frame_ctrl #(.LED_NUM(LED_NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank      (bank),
        .led_count (led_count),
        .ram_raddr (ram_raddr),
        .ram_q     (ram_q),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int    exp_q[$];
    int    addr_log[$];
    int    exp_addr[$];
    string cur_name = "init";
    int    cur_n, cur_busy, cur_low, done_base;

    int cyc = 0, hi_len = 0, low_run = 0, busy_cycles = 0;
    int busy_at_done = 0, low_at_done = 0, done_cnt = 0, pulses_frame = 0, last_rise = 0;
    bit prev_dout = 1'b0, have_rise = 1'b0, mon_en = 1'b0;

    // Line monitor: measures pulses, bit periods, busy length and the low run before done.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) done_cnt++;
            if (!mon_en) begin
                prev_dout = 1'b0; hi_len = 0; low_run = 0; busy_cycles = 0; have_rise = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done) begin
                    busy_at_done = busy_cycles;
                    low_at_done  = low_run;
                    busy_cycles  = 0;
                    low_run      = 0;
                    have_rise    = 1'b0;
                end
                if (busy && (addr_log.size() == 0 || addr_log[$] != int'(ram_raddr)))
                    addr_log.push_back(int'(ram_raddr));
                if (dout) begin
                    if (!prev_dout) begin
                        if (have_rise)
                            check($sformatf("%s_bit%0d_period", cur_name, pulses_frame),
                                  cyc - last_rise, TBIT);
                        have_rise = 1'b1;
                        last_rise = cyc;
                    end
                    hi_len++;
                    low_run = 0;
                end else begin
                    if (prev_dout) begin
                        if (exp_q.size() == 0)
                            check($sformatf("%s_unexpected_pulse", cur_name), hi_len, -1);
                        else
                            check($sformatf("%s_bit%0d_high", cur_name, pulses_frame),
                                  hi_len, exp_q.pop_front());
                        pulses_frame++;
                        hi_len = 0;
                    end
                    if (busy && !done) low_run++;
                end
                prev_dout = dout;
            end
        end
    end

    task automatic begin_frame(input string name, input bit bnk, input int cnt, input int exp_n);
        logic [DW-1:0] w;
        int last_w;
        cur_name = name;
        cur_n    = exp_n;
        exp_q.delete();
        addr_log.delete();
        exp_addr.delete();
        pulses_frame = 0;
        last_w = 0;
        for (int p = 0; p < exp_n; p++) begin
            w = mem[bnk * LED_NUM + p];
            for (int b = DW - 1; b >= 0; b--) begin
                last_w = w[b] ? T1H : T0H;
                exp_q.push_back(last_w);
            end
        end
        cur_busy = (exp_n == 0) ? TRST + 1 : 2 + exp_n * DW * TBIT + TRST + 1;
        cur_low  = (exp_n == 0) ? TRST : (TBIT - last_w) + TRST;
        if (exp_n == 0) exp_addr.push_back(bnk * LED_NUM);
        else for (int i = 0; i <= exp_n; i++) exp_addr.push_back(bnk * LED_NUM + (i % LED_NUM));
        done_base = done_cnt;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        bank = bnk;
        led_count = AW'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_frame();
        int waited = 0;
        while (done_cnt == done_base && waited < cur_busy + 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (8) @(negedge clk);
        check({cur_name, "_done_pulses"}, done_cnt - done_base, 1);
        check({cur_name, "_busy_cycles"}, busy_at_done, cur_busy);
        check({cur_name, "_low_before_done"}, low_at_done, cur_low);
        check({cur_name, "_bits_sent"}, pulses_frame, cur_n * DW);
        check({cur_name, "_bits_missing"}, exp_q.size(), 0);
        check({cur_name, "_busy_after"}, busy, 0);
        check({cur_name, "_addr_count"}, addr_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
            check($sformatf("%s_addr%0d", cur_name, i), addr_log[i], exp_addr[i]);
    endtask

    typedef struct {
        string name;
        bit    bnk;
        int    cnt;
        int    exp_n;
    } frame_vec_t;

    frame_vec_t vecs [4];

    initial begin
        int waited;
        rst_n = 1'b0;
        start = 1'b0;
        bank = 1'b0;
        led_count = '0;
        for (int i = 0; i < 2 * LED_NUM; i++) mem[i] = DW'($urandom);
        mem[0]  = 24'hA50000;
        mem[16] = 24'h123456;
        mem[17] = 24'hFEDCBA;
        mem[18] = 24'h0F0F0F;

        vecs[0] = '{name: "t1_single",  bnk: 1'b0, cnt: 1,  exp_n: 1};
        vecs[1] = '{name: "t2_bank1_3", bnk: 1'b1, cnt: 3,  exp_n: 3};
        vecs[2] = '{name: "t3_empty",   bnk: 1'b0, cnt: 0,  exp_n: 0};
        vecs[3] = '{name: "t4_clamp",   bnk: 1'b1, cnt: 31, exp_n: 16};

        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_raddr", ram_raddr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_dout", dout, 0);

        for (int i = 0; i < 4; i++) begin
            begin_frame(vecs[i].name, vecs[i].bnk, vecs[i].cnt, vecs[i].exp_n);
            finish_frame();
        end

        // Mid-frame start and bank changes must not disturb the running frame.
        begin_frame("t5_ignore", 1'b0, 2, 2);
        repeat (300) @(negedge clk);
        start = 1'b1;
        bank = 1'b1;
        led_count = AW'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (1500) @(negedge clk);
        bank = 1'b0;
        repeat (200) @(negedge clk);
        bank = 1'b1;
        finish_frame();
        bank = 1'b0;

        // Reset during bit 5 of pixel 2, then a clean full frame.
        begin_frame("t6_abort", 1'b0, 3, 3);
        waited = 0;
        while (pulses_frame < 2 * DW + 5 && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reached_pixel2", pulses_frame, 2 * DW + 5);
        waited = 0;
        while (dout !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("t6_bit_started", dout, 1);
        repeat (5) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_async_dout", dout, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_done", done, 0);
        check("t6_async_raddr", ram_raddr, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done_pulse", done_cnt - done_base, 0);
        check("t6_idle_after_reset", busy, 0);
        begin_frame("t6_restart", 1'b0, 3, 3);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
